if_stage: RTL and testbench

//   Instruction fetch stage. Drives the instruction-memory request port and

---
 rtl/if_stage.sv | 138 +++++++++++++
 tb/tb_if_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with 1-entry skid buffer and in-flight redirect kill
//
// Purpose: issues instruction-memory requests, registers the fetched
// instruction/pc pair for decode, buffers one fetch across decode stalls and
// discards a fetch that was already in flight when a redirect arrived.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   stall, flush          hazard unit: hold / invalidate the IF/ID register
//   redirect_valid/_pc    taken branch/jump target from EX (bit 0 ignored)
//   imem_req/addr         fetch request; held until imem_ready
//   imem_ready/rdata      fetch completion and returned instruction
//   instruction, pc       IF/ID register contents (pc = address of instruction)
//   if_valid              IF/ID register holds a real instruction
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic        if_valid
);

  typedef enum logic {FETCH = 1'b0, KILL = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_fetch_pc;
  logic [15:0] r_redir_pc;   // target waiting for the killed fetch to finish
  logic        r_skid_valid;
  logic [15:0] r_skid_instr;
  logic [15:0] r_skid_pc;
  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic        r_valid;

  logic        w_hs;
  logic        w_accept;
  logic        w_pending;
  logic [15:0] w_target;

  // Request is gated by rst_n so it is low for the whole reset assertion.
  assign imem_req  = rst_n & ((r_state == KILL) | ~r_skid_valid);
  // In KILL the killed fetch address stays on the bus until it completes.
  assign imem_addr = r_fetch_pc;

  assign w_hs      = imem_req & imem_ready;
  assign w_pending = imem_req & ~imem_ready;
  // Only a FETCH-state handshake without a concurrent redirect delivers data.
  assign w_accept  = w_hs & (r_state == FETCH) & ~redirect_valid;
  assign w_target  = {redirect_pc[15:1], 1'b0};

  assign instruction = r_instr;
  assign pc          = r_pc;
  assign if_valid    = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (redirect_valid)
      w_next_state = w_pending ? KILL : FETCH;
    else if (r_state == KILL && w_hs)
      w_next_state = FETCH;
  end

  // Fetch address and redirect target
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // A still-pending request must keep its address; park the target.
      if (w_pending) r_redir_pc <= w_target;
      else           r_fetch_pc <= w_target;
    end else if (r_state == KILL && w_hs) begin
      r_fetch_pc <= r_redir_pc;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + 16'd2;
    end
  end

  // Skid buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= 16'h0000;
    end else if (redirect_valid) begin
      r_skid_valid <= 1'b0;
    end else if (w_accept && stall) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_fetch_pc;
    end else if (!stall && !flush && r_skid_valid) begin
      r_skid_valid <= 1'b0;
    end
  end

  // IF/ID output register: flush > stall > skid > handshake > bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 16'h0000;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (stall) begin
      r_valid <= r_valid;
    end else if (r_skid_valid) begin
      r_valid <= 1'b1;
      r_instr <= r_skid_instr;
      r_pc    <= r_skid_pc;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_instr <= imem_rdata;
      r_pc    <= r_fetch_pc;
    end else begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instruction;
  logic [15:0] pc;
  logic        if_valid;

  int errors = 0;
  int checks = 0;

  localparam logic [15:0] NOP = 16'h0000;

  if_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .pc             (pc),
    .if_valid       (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [15:0] a);
    return a ^ 16'hC3C3;
  endfunction

  // Instruction memory contents: a fixed function of the address.
  always_comb imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] p);
    chk({tag, ".if_valid"}, {15'd0, if_valid}, {15'd0, v});
    if (v) begin
      chk({tag, ".pc"}, pc, p);
      chk({tag, ".instr"}, instruction, mem(p));
    end else begin
      chk({tag, ".instr"}, instruction, NOP);
    end
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
    chk({tag, ".imem_req"}, {15'd0, imem_req}, {15'd0, r});
    if (r) chk({tag, ".imem_addr"}, imem_addr, a);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".imem_req"}, {15'd0, imem_req}, 16'd0);
    chk({tag, ".if_valid"}, {15'd0, if_valid}, 16'd0);
    chk({tag, ".instr"}, instruction, NOP);
    chk({tag, ".pc"}, pc, 16'h0000);
    chk({tag, ".imem_addr"}, imem_addr, 16'h0000);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000; imem_ready = 1'b1;

    @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    #1 chk_req("rel", 1'b1, 16'h0000);

    // zero-wait streaming
    for (int k = 1; k <= 2; k++) begin
      tick;
      chk_out("stream", 1'b1, 16'(2 * (k - 1)));
      chk_req("stream", 1'b1, 16'(2 * k));
    end

    // ready withheld for three cycles on 0x0004
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_out("wait", 1'b0, 16'h0000);
      chk_req("wait", 1'b1, 16'h0004);
    end
    imem_ready = 1'b1;
    tick;
    chk_out("wait_done", 1'b1, 16'h0004);
    chk_req("wait_done", 1'b1, 16'h0006);

    // four-cycle stall while 0x0006 completes
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk_out("stall", 1'b1, 16'h0004);
      chk_req("stall", 1'b0, 16'h0000);
    end
    stall = 1'b0;
    tick;
    chk_out("skid_out", 1'b1, 16'h0006);
    chk_req("skid_out", 1'b1, 16'h0008);
    tick;
    chk_out("after_skid", 1'b1, 16'h0008);
    chk_req("after_skid", 1'b1, 16'h000A);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk_out("run", 1'b1, 16'(16'h000A + 2 * k));
      chk_req("run", 1'b1, 16'(16'h000C + 2 * k));
    end

    // redirect while 0x0010 is pending -> KILL
    imem_ready = 1'b0;
    tick;
    chk_out("pend10", 1'b0, 16'h0000);
    chk_req("pend10", 1'b1, 16'h0010);
    redirect_valid = 1'b1; redirect_pc = 16'h0101; flush = 1'b1;
    tick;
    chk_out("kill", 1'b0, 16'h0000);
    chk_req("kill", 1'b1, 16'h0010);
    redirect_valid = 1'b0; flush = 1'b0;
    tick;
    chk_out("kill_hold", 1'b0, 16'h0000);
    chk_req("kill_hold", 1'b1, 16'h0010);
    imem_ready = 1'b1;
    tick;
    chk_out("kill_drop", 1'b0, 16'h0000);
    chk_req("kill_drop", 1'b1, 16'h0100);
    tick;
    chk_out("target", 1'b1, 16'h0100);
    chk_req("target", 1'b1, 16'h0102);

    // redirect + flush with the skid full; wrap at 0xFFFE
    stall = 1'b1;
    tick;
    chk_out("fill_skid", 1'b1, 16'h0100);
    chk_req("fill_skid", 1'b0, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF; flush = 1'b1;
    tick;
    chk_out("redir_flush", 1'b0, 16'h0000);
    chk_req("redir_flush", 1'b1, 16'hFFFE);
    redirect_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    tick;
    chk_out("wrap_top", 1'b1, 16'hFFFE);
    chk_req("wrap_top", 1'b1, 16'h0000);
    tick;
    chk_out("wrap_zero", 1'b1, 16'h0000);
    chk_req("wrap_zero", 1'b1, 16'h0002);

    // reset asserted while in KILL
    imem_ready = 1'b0;
    tick;
    chk_out("pend2", 1'b0, 16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    tick;
    chk_req("kill2", 1'b1, 16'h0002);
    redirect_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    imem_ready = 1'b1;
    rst_n = 1'b1;
    #1 chk_req("restart", 1'b1, 16'h0000);
    tick;
    chk_out("restart_out", 1'b1, 16'h0000);
    chk_req("restart_out", 1'b1, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
